// File: rtl/canvas_pkg.sv
// rtl/canvas_pkg.sv - shared FSM states, colour codes and pixel addressing for the canvas
package canvas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAINT,
    CLEAR
  } state_e;

  localparam logic [2:0] COLOR_ERASE  = 3'b000;
  localparam logic [2:0] COLOR_RED    = 3'b100;
  localparam logic [2:0] COLOR_GREEN  = 3'b010;
  localparam logic [2:0] COLOR_BLUE   = 3'b001;
  localparam logic [2:0] COLOR_YELLOW = 3'b110;
  localparam logic [2:0] COLOR_PURPLE = 3'b101;

  localparam int MAX_COORD_BITS = 8;

  // Row-major pixel address {y, x}; callers truncate to their 2*COORD_BITS width.
  function automatic logic [2*MAX_COORD_BITS-1:0] pixel_addr(
    input logic [MAX_COORD_BITS-1:0] x,
    input logic [MAX_COORD_BITS-1:0] y,
    input int unsigned               coord_bits
  );
    pixel_addr = ({{MAX_COORD_BITS{1'b0}}, y} << coord_bits) | {{MAX_COORD_BITS{1'b0}}, x};
  endfunction

endpackage

// File: rtl/canvas_ram.sv
// rtl/canvas_ram.sv - simple dual-port RAM, one write port and one synchronous read port
module canvas_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Read-before-write: a same-address read this cycle sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/canvas_buffer.sv
// rtl/canvas_buffer.sv - canvas frame buffer: brush painting, full clear, raster read with border
module canvas_buffer
  import canvas_pkg::*;
#(
  parameter int                    COORD_BITS   = 7,
  parameter int                    COLOR_BITS   = 3,
  parameter int                    RD_BITS      = 10,
  parameter logic [COLOR_BITS-1:0] ERASE_COLOR  = 3'b000,
  parameter logic [COLOR_BITS-1:0] BORDER_COLOR = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  brush,
  input  logic [1:0]            brush_size,
  input  logic [COLOR_BITS-1:0] new_color,
  input  logic [COORD_BITS-1:0] wx,
  input  logic [COORD_BITS-1:0] wy,
  input  logic                  clear,
  input  logic [RD_BITS-1:0]    rx,
  input  logic [RD_BITS-1:0]    ry,
  output logic [COLOR_BITS-1:0] color_code,
  output logic                  busy
);

  localparam int                  ADDR_W    = 2 * COORD_BITS;
  localparam logic [ADDR_W-1:0]   LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [RD_BITS-1:0]  RD_SIDE   = {{(RD_BITS-1){1'b0}}, 1'b1} << COORD_BITS;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [COORD_BITS-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [1:0]            size_q, size_d, dx_q, dx_d, dy_q, dy_d;
  logic [COLOR_BITS-1:0] col_q, col_d;
  logic                  oob_q, oob_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  we;
  logic [ADDR_W-1:0]     waddr, raddr;
  logic [COLOR_BITS-1:0] wdata, rdata;
  logic [COORD_BITS:0]   px, py;

  // One extra bit so a stroke running off the right/bottom edge is clipped, not wrapped.
  assign px = {1'b0, ox_q} + {{(COORD_BITS-1){1'b0}}, dx_q};
  assign py = {1'b0, oy_q} + {{(COORD_BITS-1){1'b0}}, dy_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    size_d  = size_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    col_d   = col_q;
    we      = 1'b0;
    waddr   = ADDR_W'(pixel_addr(MAX_COORD_BITS'(px[COORD_BITS-1:0]),
                                 MAX_COORD_BITS'(py[COORD_BITS-1:0]), COORD_BITS));
    wdata   = col_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (brush) begin
          state_d = PAINT;
          ox_d    = wx;
          oy_d    = wy;
          size_d  = brush_size;
          col_d   = new_color;
          dx_d    = 2'd0;
          dy_d    = 2'd0;
        end
      end
      PAINT: begin
        we = !px[COORD_BITS] && !py[COORD_BITS];
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (dx_q == size_q) begin
          dx_d = 2'd0;
          if (dy_q == size_q) begin
            state_d = IDLE;
          end else begin
            dy_d = dy_q + 2'd1;
          end
        end else begin
          dx_d = dx_q + 2'd1;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = ERASE_COLOR;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign raddr      = ADDR_W'(pixel_addr(MAX_COORD_BITS'(rx[COORD_BITS-1:0]),
                                         MAX_COORD_BITS'(ry[COORD_BITS-1:0]), COORD_BITS));
  assign oob_d      = (rx >= RD_SIDE) || (ry >= RD_SIDE);
  assign rd_valid_d = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      size_q     <= 2'd0;
      dx_q       <= 2'd0;
      dy_q       <= 2'd0;
      col_q      <= ERASE_COLOR;
      oob_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      size_q     <= size_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      col_q      <= col_d;
      oob_q      <= oob_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  canvas_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (COLOR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // RAM contents are not reset, so the output is forced to the erase colour until the first read lands.
  assign color_code = !rd_valid_q ? ERASE_COLOR : (oob_q ? BORDER_COLOR : rdata);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_canvas_buffer.sv
// tb/tb_canvas_buffer.sv - scoreboard bench for canvas_buffer on an 8x8 canvas
module tb_canvas_buffer;

  localparam logic [2:0] ERASE  = 3'b101;
  localparam logic [2:0] BORDER = 3'b110;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       brush = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] brush_size = 2'd0;
  logic [2:0] new_color = 3'd0;
  logic [2:0] wx = 3'd0, wy = 3'd0;
  logic [9:0] rx = 10'd0, ry = 10'd0;
  logic [2:0] color_code;
  logic       busy;

  int   total = 0;
  int   bad = 0;
  logic rd_req = 1'b0;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] exp;
  } rd_t;
  rd_t exp_q[$];

  always #5 clk = ~clk;

  canvas_buffer #(
    .COORD_BITS   (3),
    .COLOR_BITS   (3),
    .RD_BITS      (10),
    .ERASE_COLOR  (ERASE),
    .BORDER_COLOR (BORDER)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .brush      (brush),
    .brush_size (brush_size),
    .new_color  (new_color),
    .wx         (wx),
    .wy         (wy),
    .clear      (clear),
    .rx         (rx),
    .ry         (ry),
    .color_code (color_code),
    .busy       (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: a read requested before an edge is answered just after that edge.
  always @(posedge clk) begin
    if (rd_req) begin
      rd_t e;
      #1;
      if (exp_q.size() == 0) begin
        chk("read_queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("read(%0d,%0d)", e.x, e.y), int'(color_code), int'(e.exp));
      end
    end
  end

  task automatic rd(input int x, input int y, input logic [2:0] e);
    rd_t r;
    r.x = x; r.y = y; r.exp = e;
    rx = 10'(x);
    ry = 10'(y);
    rd_req = 1'b1;
    exp_q.push_back(r);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic count_busy(input string nm, input int exp);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 300);
    chk(nm, n, exp);
    @(negedge clk);
  endtask

  task automatic stroke(input int x, input int y, input int size, input logic [2:0] col,
                        input string nm, input int exp_cycles);
    wx = 3'(x);
    wy = 3'(y);
    brush_size = 2'(size);
    new_color = col;
    brush = 1'b1;
    @(posedge clk);
    #1 brush = 1'b0;
    count_busy(nm, exp_cycles);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    // Reset and power-up sweep
    repeat (3) @(posedge clk);
    #1;
    chk("reset_color", int'(color_code), int'(ERASE));
    chk("reset_busy", int'(busy), 1);
    @(negedge clk);
    reset = 1'b1;
    count_busy("reset_clear_cycles", 64);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        rd(x, y, ERASE);

    // 2x2 stroke
    stroke(2, 3, 1, 3'b010, "stroke2x2_cycles", 4);
    rd(2, 3, 3'b010); rd(3, 3, 3'b010); rd(2, 4, 3'b010); rd(3, 4, 3'b010);
    rd(4, 3, ERASE);  rd(1, 3, ERASE);  rd(2, 5, ERASE);

    // 4x4 stroke in the corner: clipped, no wrap
    stroke(7, 7, 3, 3'b001, "stroke_clip_cycles", 16);
    rd(7, 7, 3'b001); rd(0, 0, ERASE); rd(0, 7, ERASE); rd(7, 0, ERASE); rd(6, 7, ERASE);

    // Border substitution and plain in-canvas read
    rd(8, 0, BORDER); rd(3, 1000, BORDER); rd(3, 4, 3'b010);
    rd(7, 8, BORDER); rd(1023, 1023, BORDER); rd(7, 7, 3'b001);

    // brush and clear together: clear wins
    wx = 3'd0; wy = 3'd0; brush_size = 2'd0; new_color = 3'b111;
    brush = 1'b1; clear = 1'b1;
    @(posedge clk);
    #1 brush = 1'b0; clear = 1'b0;
    count_busy("brush_and_clear_cycles", 64);
    rd(0, 0, ERASE); rd(2, 3, ERASE); rd(7, 7, ERASE);

    // clear on the second PAINT cycle aborts the stroke
    wx = 3'd1; wy = 3'd1; brush_size = 2'd3; new_color = 3'b011;
    brush = 1'b1;
    @(posedge clk);
    #1 brush = 1'b0;
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    count_busy("abort_clear_cycles", 64);
    rd(1, 1, ERASE); rd(2, 1, ERASE); rd(4, 4, ERASE);

    // brush held while busy is ignored
    wx = 3'd0; wy = 3'd0; brush_size = 2'd1; new_color = 3'b100;
    brush = 1'b1;
    @(posedge clk);
    #1 wx = 3'd5; wy = 3'd5; new_color = 3'b111;
    repeat (3) @(posedge clk);
    #1 brush = 1'b0;
    count_busy("ignored_brush_tail_cycles", 1);
    repeat (3) @(negedge clk);
    chk("idle_after_ignored_brush", int'(busy), 0);
    rd(0, 0, 3'b100); rd(1, 0, 3'b100); rd(0, 1, 3'b100); rd(1, 1, 3'b100);
    rd(5, 5, ERASE);  rd(6, 6, ERASE);  rd(2, 0, ERASE);

    // read of the pixel in the very cycle it is written
    wx = 3'd6; wy = 3'd1; brush_size = 2'd0; new_color = 3'b011;
    brush = 1'b1;
    @(posedge clk);
    #1 brush = 1'b0;
    @(negedge clk);
    begin
      rd_t r;
      r.x = 6; r.y = 1; r.exp = ERASE;
      rx = 10'd6; ry = 10'd1; rd_req = 1'b1;
      exp_q.push_back(r);
      @(negedge clk);
      r.exp = 3'b011;
      exp_q.push_back(r);
      @(negedge clk);
      rd_req = 1'b0;
    end
    chk("idle_after_single_pixel", int'(busy), 0);
    rd(6, 1, 3'b011);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
